// File: rtl/fifo_ctrl_flags_if.sv
// Handshake and status bundle between the FIFO controller and its
// producer/consumer logic. The controller side uses the slave modport.
interface fifo_ctrl_flags_if #(
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              wr_en;
  logic              rd_en;
  logic              wr_accept;
  logic              rd_accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  clr, wr_en, rd_en,
    output wr_accept, rd_accept, wr_addr, rd_addr, count,
           empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport master (
    output clr, wr_en, rd_en,
    input  wr_accept, rd_accept, wr_addr, rd_addr, count,
           empty, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_flags.sv
// FIFO pointer and status controller: qualifies write/read requests,
// owns the wrap-bit pointers that address the storage RAM, and keeps a
// registered occupancy count plus status and sticky error flags.
module fifo_ctrl_flags #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_ctrl_flags_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AE_V    = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_V    = AF_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q,  count_d;
  logic            empty_q,  empty_d;
  logic            full_q,   full_d;
  logic            ae_q,     ae_d;
  logic            af_q,     af_d;
  logic            ovf_q,    ovf_d;
  logic            udf_q,    udf_d;
  logic            wr_accept;
  logic            rd_accept;

  // Request qualification from current flags; clr blocks both sides.
  always_comb begin
    rd_accept = bus.rd_en & ~empty_q & ~bus.clr;
    // A write into a full FIFO is legal only when a read frees a slot.
    wr_accept = bus.wr_en & (~full_q | rd_accept) & ~bus.clr;
  end

  // Next-state pointers, count and flags; flags follow the next count so
  // they are valid from the edge that performs the access.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_accept};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_accept};
    count_d  = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
              (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    ae_d    = (count_d <= AE_V);
    af_d    = (count_d >= AF_V);
    ovf_d   = ovf_q | (bus.wr_en & ~wr_accept);
    udf_d   = udf_q | (bus.rd_en & ~rd_accept);
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      ae_d     = 1'b1;
      af_d     = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.wr_accept    = wr_accept;
  assign bus.rd_accept    = rd_accept;
  assign bus.wr_addr      = wr_ptr_q[ADDR_W-1:0];
  assign bus.rd_addr      = rd_ptr_q[ADDR_W-1:0];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Compile-time guard on the legal parameter range.
  if (ADDR_W < 2 || AE_THRESH <= 0 || AE_THRESH >= AF_THRESH ||
      AF_THRESH >= (1 << ADDR_W)) begin : g_bad_params
    $error("fifo_ctrl_flags: illegal ADDR_W/AE_THRESH/AF_THRESH combination");
  end

endmodule

// File: doc/fifo_ctrl_flags.md
# fifo_ctrl_flags

Parametrised FIFO pointer and status controller: owns the write and read pointers of a dual-port-RAM FIFO, qualifies write/read requests, and produces registered occupancy count, empty/full, programmable almost-empty/almost-full, and sticky overflow/underflow error flags. It sits between the FIFO's producer/consumer handshakes and the storage array. It drives the RAM write and read addresses directly.

## Interface
Parameters:
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (16 by default)
- AE_THRESH, 4, almost_empty asserted while count <= AE_THRESH
- AF_THRESH, 12, almost_full asserted while count >= AF_THRESH
- Legal range: ADDR_W >= 2, 0 < AE_THRESH < AF_THRESH < DEPTH

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- clr  input  1  synchronous clear; returns all state to reset values
- wr_en  input  1  write request
- rd_en  input  1  read request
- wr_accept  output  1  write performed this cycle (combinational)
- rd_accept  output  1  read performed this cycle (combinational)
- wr_addr  output  ADDR_W  RAM location the next accepted write uses (registered)
- rd_addr  output  ADDR_W  RAM location the next accepted read uses (registered)
- count  output  ADDR_W+1  current occupancy, 0..DEPTH (registered)
- empty, full, almost_empty, almost_full  output  1 each  status flags (registered)
- overflow, underflow  output  1 each  sticky error flags (registered)

## Operation
- Internal pointers wr_ptr, rd_ptr are ADDR_W+1 bits; MSB is a wrap bit, low ADDR_W bits drive wr_addr/rd_addr. Pointers increment modulo 2**(ADDR_W+1); address wraps DEPTH-1 -> 0 and toggles the wrap bit.
- empty = (wr_ptr == rd_ptr); full = low bits equal and wrap bits differ. Equivalent to count == 0 / count == DEPTH; both forms must agree at all times.
- Acceptance rules:
  - rd_accept = rd_en & !empty.
  - wr_accept = wr_en & (!full | rd_accept): a write while full is taken only when a read is accepted in the same cycle.
  - A read while empty is rejected even if a write occurs the same cycle; there is no fall-through.
- Count update: +1 on write-only, -1 on read-only, unchanged on both or neither. It can never exceed DEPTH or go below 0.
- Flags are computed from next-state count and registered, so they are valid from the edge that performs the access.
- overflow sets on wr_en & !wr_accept; underflow sets on rd_en & !rd_accept. Both hold until clr or reset, and a rejected access changes no other state.
- clr has priority over wr_en/rd_en in the same cycle. wr_accept and rd_accept are forced to 0 while clr is high.
- Reset and clr values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.

## Timing
- Reset: asserting rst_n low forces all registered outputs to reset values immediately, independent of clk. Release is synchronous to the next rising edge; the first access may occur in the first cycle after release.
- wr_accept/rd_accept: same-cycle combinational from wr_en/rd_en and current flags. There are no paths from clr except the forcing to 0.
- Accepted write in cycle N: RAM writes at wr_addr in cycle N; wr_addr, count and flags reflect it after the edge ending cycle N.
- Accepted read in cycle N: consumer samples RAM at rd_addr in cycle N; rd_addr advances at the edge ending cycle N.
- Back-to-back accesses every cycle are supported at full throughput, including across wrap-around.
- Reset mid-operation discards all contents; no partial state survives.

## Test plan
All scenarios use ADDR_W=4, AE_THRESH=4, AF_THRESH=12.
- Reset/idle: assert rst_n=0 mid-cycle with count=7 -> all outputs go to reset values without a clock edge. After release with no requests -> empty=1, almost_empty=1, count=0.
- Fill: 16 consecutive writes -> count 1..16. almost_empty clears when count reaches 5; almost_full sets when count reaches 12; full=1 at 16. A 17th write gives wr_accept=0, overflow=1, and count stays 16.
- Drain: 16 consecutive reads from full -> full clears at 15, almost_full clears at 11, empty=1 at 0. A 17th read gives underflow=1, and rd_addr is unchanged.
- Simultaneous:
  - When full, wr_en=rd_en=1 -> both accepted; count stays 16, and both addresses advance.
  - When empty, wr_en=rd_en=1 -> only the write is accepted; count=1, and underflow=1.
- Wrap-around: 40 cycles of a streaming write+read pattern holding count at 3 -> addresses wrap 15->0 at least twice. empty and full never assert falsely, and count stays 3.
- clr: with count=9 and overflow=1, assert clr together with wr_en=1 -> next cycle count=0, empty=1, overflow=0, and wr_addr=0.
